// File: rtl/demux2_buf_fifo2.sv
// fifo2: two-entry synchronous FIFO with registered storage and head output.
// Pointers are one bit wide and wrap naturally modulo the depth.
module fifo2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = 1;
  localparam int unsigned CNT_W = 2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      // push and pop together leave the occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/demux2_buf.sv
// demux2_buf: routes a single word stream to one of two buffered output ports.
// in_ready depends only on in_sel and the selected FIFO's fill state.
module demux2_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);
  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;

  assign in_ready   = in_sel ? !full1 : !full0;
  assign push0      = in_valid && in_ready && !in_sel;
  assign push1      = in_valid && in_ready && in_sel;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .wdata (in_data),
    .full  (full0),
    .empty (empty0),
    .head  (out0_data)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .wdata (in_data),
    .full  (full1),
    .empty (empty1),
    .head  (out1_data)
  );
endmodule

// File: tb/tb_demux2_buf.sv
// tb_demux2_buf: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and per-port delivery logs.
module tb_demux2_buf;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready = 1'b0;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] log0[$];
  logic [15:0] log1[$];

  always #5 clk = ~clk;

  demux2_buf #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each port is an ideal 2-deep queue
  always @(posedge clk) begin
    bit acc, p0, p1;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      acc = in_valid && (in_sel ? (q1.size() < 2) : (q0.size() < 2));
      p0  = out0_ready && (q0.size() > 0);
      p1  = out1_ready && (q1.size() > 0);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
      if (out0_valid && out0_ready) log0.push_back(out0_data);
      if (out1_valid && out1_ready) log1.push_back(out1_data);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", {15'b0, in_ready},
            {15'b0, in_sel ? (q1.size() < 2) : (q0.size() < 2)});
      check("out0_valid", {15'b0, out0_valid}, {15'b0, q0.size() != 0});
      check("out1_valid", {15'b0, out1_valid}, {15'b0, q1.size() != 0});
      if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic sel, input logic [15:0] d, input int budget);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    for (int i = 0; i < budget && !done; i++) begin
      #1;
      done = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    if (!done) check("offer_timeout", d, 16'hFFFF);
  endtask

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  initial begin
    exp0 = '{16'hA001, 16'hA003, 16'h00FF, 16'h1234, 16'h5678};
    exp1 = '{16'hB002, 16'h0011, 16'h0022, 16'h0033,
             16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};

    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check("rst_out0_valid", {15'b0, out0_valid}, 16'h0);
    check("rst_out1_valid", {15'b0, out1_valid}, 16'h0);
    check("rst_out0_data", out0_data, 16'h0000);
    check("rst_out1_data", out1_data, 16'h0000);
    check("rst_in_ready", {15'b0, in_ready}, 16'h1);
    cyc();

    // Alternating route, both consumers always ready
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hA001; cyc();
    check("alt_a001", out0_data, 16'hA001);
    check("alt_a001_v", {15'b0, out0_valid}, 16'h1);
    in_sel = 1'b1; in_data = 16'hB002; cyc();
    check("alt_b002", out1_data, 16'hB002);
    check("alt_out0_drained", {15'b0, out0_valid}, 16'h0);
    in_sel = 1'b0; in_data = 16'hA003; cyc();
    check("alt_a003", out0_data, 16'hA003);
    in_valid = 1'b0; cyc();

    // Port 1 stall while port 0 keeps flowing
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h0011; cyc();
    in_data = 16'h0022; cyc();
    in_data = 16'h0033; #1;
    check("stall_in_ready_low", {15'b0, in_ready}, 16'h0);
    cyc();
    in_sel = 1'b0; in_data = 16'h00FF; #1;
    check("stall_port0_ready", {15'b0, in_ready}, 16'h1);
    cyc();
    check("stall_00ff", out0_data, 16'h00FF);
    check("stall_out1_head", out1_data, 16'h0011);
    out1_ready = 1'b1;
    offer(1'b1, 16'h0033, 6);
    cyc(); cyc();

    // Push and pop on port 0 at count 1
    out0_ready = 1'b0;
    offer(1'b0, 16'h1234, 3);
    out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h5678; cyc();
    in_valid = 1'b0;
    check("pp_data", out0_data, 16'h5678);
    check("pp_valid", {15'b0, out0_valid}, 16'h1);
    cyc();
    check("pp_count1_drained", {15'b0, out0_valid}, 16'h0);

    // Wrap-around through port 1 with random back-pressure
    for (int w = 1; w <= 7; w++) begin
      out1_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b1; in_sel = 1'b1; in_data = 16'(w);
      for (int t = 0; t < 20; t++) begin
        bit ok;
        #1;
        ok = in_ready;
        cyc();
        out1_ready = 1'($urandom_range(0, 1));
        if (ok) break;
        if (t == 19) check("wrap_timeout", 16'(w), 16'hFFFF);
      end
      in_valid = 1'b0;
    end
    out1_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("wrap_empty", {15'b0, out1_valid}, 16'h0);

    // Reset mid-operation; the handshake during reset must be ignored
    out0_ready = 1'b0;
    offer(1'b0, 16'hDEAD, 3);
    offer(1'b0, 16'hBEEF, 3);
    check("mid_full", {15'b0, in_ready}, 16'h0);
    reset = 1'b1; out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hCAFE;
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_valid", {15'b0, out0_valid}, 16'h0);
    check("mid_data", out0_data, 16'h0000);
    check("mid_in_ready", {15'b0, in_ready}, 16'h1);
    cyc(); cyc(); cyc();

    check("log0_len", 16'(log0.size()), 16'(exp0.size()));
    for (int i = 0; i < exp0.size() && i < log0.size(); i++) check("log0_word", log0[i], exp0[i]);
    check("log1_len", 16'(log1.size()), 16'(exp1.size()));
    for (int i = 0; i < exp1.size() && i < log1.size(); i++) check("log1_word", log1[i], exp1[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
